// File: rtl/posit_fmau_pkg.sv
// Shared constants and types for the posit FMAU scheduler.
package posit_fmau_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ID_W   = 3;

   // Precision codes and their lane counts: P8 x4, P16 x2, P32 x1.
   localparam logic [1:0] PREC_P8  = 2'b00;
   localparam logic [1:0] PREC_P16 = 2'b01;
   localparam logic [1:0] PREC_P32 = 2'b10;
   localparam logic [1:0] PREC_RSV = 2'b11;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr upward with wrap-around.
// idx always reports the winner; gnt is only driven when en is high.
module rr_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   input  logic                    en,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] idx
);

   localparam int unsigned IDX_W = $clog2(NREQ);

   logic             found;
   logic [IDX_W:0]   k;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      gnt   = '0;
      k     = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         k = {1'b0, ptr} + (IDX_W+1)'(i);
         if (k >= (IDX_W+1)'(NREQ)) begin
            k = k - (IDX_W+1)'(NREQ);
         end
         if (!found && req[k[IDX_W-1:0]]) begin
            found = 1'b1;
            idx   = k[IDX_W-1:0];
         end
      end
      if (en && found) begin
         gnt[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/posit_fmau_sched.sv
// Round-robin scheduler sharing one pipelined posit FMAU among NREQ requesters.
// Optional FMAU_SCHED_PREC_LOCK_EN: hold issue while precision changes and ops are in flight.
module posit_fmau_sched
   import posit_fmau_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned LAT   = 3,
   parameter int unsigned DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*32-1:0]      req_a,
   input  logic [NREQ*32-1:0]      req_b,
   input  logic [NREQ*32-1:0]      req_c,
   input  logic [NREQ*32-1:0]      req_d,
   input  logic [NREQ*2-1:0]       req_in_pre,
   input  logic [NREQ*2-1:0]       req_out_pre,
   output logic [31:0]             fmau_a,
   output logic [31:0]             fmau_b,
   output logic [31:0]             fmau_c,
   output logic [31:0]             fmau_d,
   output logic [1:0]              fmau_in_pre,
   output logic [1:0]              fmau_out_pre,
   input  logic [31:0]             fmau_res,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [31:0]             rsp_data
);

   localparam int unsigned IDX_W = $clog2(NREQ);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned INF_W = $clog2(LAT + 2);

   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]  win_idx;
   logic [NREQ-1:0]   gnt;
   logic [1:0]        win_in_pre, win_out_pre;
   logic              accept, credit_ok, lock_stall, arb_en;

   tag_t              tag_q [LAT+1];
   tag_t              tag_d;
   logic              retire;
   logic [INF_W-1:0]  inflight_q, inflight_d;
   logic              unused_tag_id;

   logic [IDX_W-1:0]  mem_id   [DEPTH];
   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
   logic              push, pop;

   assign win_in_pre  = req_in_pre[win_idx*2 +: 2];
   assign win_out_pre = req_out_pre[win_idx*2 +: 2];

   // Pop in the same cycle is deliberately not credited.
   assign credit_ok = (32'(fifo_cnt_q) + 32'(inflight_q)) < DEPTH;

`ifdef FMAU_SCHED_PREC_LOCK_EN
   logic [3:0] last_pre_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_pre_q <= '0;
      end else if (accept) begin
         last_pre_q <= {win_in_pre, win_out_pre};
      end
   end

   // Winner is stalled, not skipped, so it goes first once the pipe drains.
   assign lock_stall = (inflight_q != '0) && ({win_in_pre, win_out_pre} != last_pre_q);
`else
   assign lock_stall = 1'b0;
`endif

   assign arb_en = !rst && credit_ok && !lock_stall;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .en  (arb_en),
      .gnt (gnt),
      .idx (win_idx)
   );

   assign req_ready = gnt;
   assign accept    = |gnt;
   assign retire    = tag_q[LAT].valid;
   assign push      = retire;
   assign pop       = rsp_valid && rsp_ready;

   assign tag_d.valid   = accept;
   assign tag_d.id      = ID_W'(win_idx);
   assign unused_tag_id = ^tag_q[LAT].id;

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      inflight_d = inflight_q;
      fifo_cnt_d = fifo_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (accept) begin
         rr_ptr_d = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
      end
      case ({accept, retire})
         2'b10:   inflight_d = inflight_q + INF_W'(1);
         2'b01:   inflight_d = inflight_q - INF_W'(1);
         default: ;
      endcase
      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
         default: ;
      endcase
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         inflight_q   <= '0;
         fifo_cnt_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fmau_a       <= '0;
         fmau_b       <= '0;
         fmau_c       <= '0;
         fmau_d       <= '0;
         fmau_in_pre  <= '0;
         fmau_out_pre <= '0;
         for (int unsigned i = 0; i <= LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         inflight_q <= inflight_d;
         fifo_cnt_q <= fifo_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         if (accept) begin
            fmau_a       <= req_a[win_idx*32 +: 32];
            fmau_b       <= req_b[win_idx*32 +: 32];
            fmau_c       <= req_c[win_idx*32 +: 32];
            fmau_d       <= req_d[win_idx*32 +: 32];
            fmau_in_pre  <= win_in_pre;
            fmau_out_pre <= win_out_pre;
         end
         tag_q[0] <= tag_d;
         for (int unsigned i = 1; i <= LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Storage only; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_id[wr_ptr_q]   <= tag_q[LAT].id[IDX_W-1:0];
         mem_data[wr_ptr_q] <= fmau_res;
      end
   end

   assign rsp_valid = (fifo_cnt_q != '0);
   assign rsp_id    = rsp_valid ? mem_id[rd_ptr_q] : '0;
   assign rsp_data  = rsp_valid ? mem_data[rd_ptr_q] : '0;

endmodule

// File: tb/tb_posit_fmau_sched.sv
// Directed bench for posit_fmau_sched with a stand-in FMAU pipeline and response scoreboard.
module tb_posit_fmau_sched;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned LAT   = 3;
   localparam int unsigned DEPTH = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*32-1:0] req_a, req_b, req_c, req_d;
   logic [NREQ*2-1:0] req_in_pre, req_out_pre;
   logic [31:0]       fmau_a, fmau_b, fmau_c, fmau_d, fmau_res;
   logic [1:0]        fmau_in_pre, fmau_out_pre;
   logic              rsp_valid, rsp_ready;
   logic [1:0]        rsp_id;
   logic [31:0]       rsp_data;

   int nchk = 0;
   int nerr = 0;
   int rsp_cnt = 0;

   posit_fmau_sched #(
      .NREQ  (NREQ),
      .LAT   (LAT),
      .DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_c        (req_c),
      .req_d        (req_d),
      .req_in_pre   (req_in_pre),
      .req_out_pre  (req_out_pre),
      .fmau_a       (fmau_a),
      .fmau_b       (fmau_b),
      .fmau_c       (fmau_c),
      .fmau_d       (fmau_d),
      .fmau_in_pre  (fmau_in_pre),
      .fmau_out_pre (fmau_out_pre),
      .fmau_res     (fmau_res),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_data     (rsp_data)
   );

   always #5 clk = ~clk;

   // Stand-in FMAU arithmetic: any operand or precision corruption changes the result.
   function automatic logic [31:0] fm(input logic [31:0] a, b, c, d, input logic [1:0] ip, op);
      return a ^ {b[30:0], b[31]} ^ {c[29:0], c[31:30]} ^ ~d ^ {28'h0, ip, op};
   endfunction

   logic [31:0] mp [LAT];
   always @(posedge clk) begin
      mp[0] <= fm(fmau_a, fmau_b, fmau_c, fmau_d, fmau_in_pre, fmau_out_pre);
      for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
   end
   assign fmau_res = mp[LAT-1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
   } exp_t;
   exp_t sbq[$];
   exp_t e;

   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            if (sbq.size() == 0) begin
               nchk++;
               nerr++;
               $display("FAIL unexpected_rsp: got id %0d data 0x%0h, required no response",
                        rsp_id, rsp_data);
            end else begin
               e = sbq.pop_front();
               chk("sb_rsp_id", 64'(rsp_id), 64'(e.id));
               chk("sb_rsp_data", 64'(rsp_data), 64'(e.data));
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               e.id   = 2'(i);
               e.data = fm(req_a[i*32 +: 32], req_b[i*32 +: 32], req_c[i*32 +: 32],
                           req_d[i*32 +: 32], req_in_pre[i*2 +: 2], req_out_pre[i*2 +: 2]);
               sbq.push_back(e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_req();
      req_valid   = '0;
      req_a       = '0;
      req_b       = '0;
      req_c       = '0;
      req_d       = '0;
      req_in_pre  = '0;
      req_out_pre = '0;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, b, c, d, input logic [1:0] ip, op);
      req_valid[i]        = 1'b1;
      req_a[i*32 +: 32]   = a;
      req_b[i*32 +: 32]   = b;
      req_c[i*32 +: 32]   = c;
      req_d[i*32 +: 32]   = d;
      req_in_pre[i*2 +: 2]  = ip;
      req_out_pre[i*2 +: 2] = op;
   endtask

   task automatic do_reset();
      step();
      clr_req();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      int          id;
      logic [31:0] a, b, c, d;
      logic [1:0]  ip, op;
      logic [3:0]  exp_ready;
      logic [31:0] exp_res;
   } vec_t;
   vec_t vecs [4];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int acc, seen, stall;
      bit got;
      vecs[0] = '{2, 32'h40000000, 32'h40000000, 32'h0, 32'h0, 2'b10, 2'b10, 4'b0100, 32'h0};
      vecs[1] = '{0, 32'h3F800000, 32'hC0000000, 32'h12345678, 32'h0, 2'b00, 2'b01, 4'b0001, 32'h0};
      vecs[2] = '{3, 32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h7F7F7F7F, 2'b11, 2'b11,
                  4'b1000, 32'h0};
      vecs[3] = '{1, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0, 2'b01, 2'b00,
                  4'b0010, 32'h0};
      foreach (vecs[v]) vecs[v].exp_res = fm(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d,
                                              vecs[v].ip, vecs[v].op);

      // Reset values, with requests pending during reset.
      rst = 1'b1;
      rsp_ready = 1'b1;
      clr_req();
      req_valid = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'h0);
      chk("rst_fmau_a", 64'(fmau_a), 64'h0);
      chk("rst_fmau_pre", 64'({fmau_in_pre, fmau_out_pre}), 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_rsp_id", 64'(rsp_id), 64'h0);
      chk("rst_rsp_data", 64'(rsp_data), 64'h0);
      do_reset();

      // Single-request vectors: issue latency, operand pass-through, response timing.
      foreach (vecs[v]) begin
         step();
         set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d, vecs[v].ip, vecs[v].op);
         @(negedge clk);
         chk("vec_ready", 64'(req_ready), 64'(vecs[v].exp_ready));
         step();
         clr_req();
         @(negedge clk);
         chk("vec_fmau_a", 64'(fmau_a), 64'(vecs[v].a));
         chk("vec_fmau_b", 64'(fmau_b), 64'(vecs[v].b));
         chk("vec_fmau_c", 64'(fmau_c), 64'(vecs[v].c));
         chk("vec_fmau_d", 64'(fmau_d), 64'(vecs[v].d));
         chk("vec_fmau_in_pre", 64'(fmau_in_pre), 64'(vecs[v].ip));
         chk("vec_fmau_out_pre", 64'(fmau_out_pre), 64'(vecs[v].op));
         repeat (LAT) @(negedge clk);
         chk("vec_rsp_early", 64'(rsp_valid), 64'h0);
         @(negedge clk);
         chk("vec_rsp_valid", 64'(rsp_valid), 64'h1);
         chk("vec_rsp_id", 64'(rsp_id), 64'(vecs[v].id));
         chk("vec_rsp_data", 64'(rsp_data), 64'(vecs[v].exp_res));
         repeat (2) step();
      end

      // All requesters valid: strict rotation, all responses in issue order.
      do_reset();
      rsp_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         for (int i = 0; i < NREQ; i++) begin
            set_req(i, 32'(i) * 32'h10000000 + 32'(k), ~(32'(k) << 4), 32'(k * 7),
                    32'(i), 2'(i), 2'(k));
         end
         @(negedge clk);
         chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      end
      step();
      clr_req();
      repeat (12) step();
      chk("rr_rsp_count", 64'(rsp_cnt), 64'd12);
      chk("rr_sb_empty", 64'(sbq.size()), 64'h0);

      // Credit limit with consumer stalled.
      do_reset();
      rsp_ready = 1'b0;
      acc = 0;
      for (int n = 0; n < 16; n++) begin
         step();
         set_req(1, 32'hC0000000 + 32'(n), 32'h1, 32'h2, 32'(n), 2'b10, 2'b01);
         @(negedge clk);
         if (req_ready[1]) acc++;
      end
      chk("credit_accepts", 64'(acc), 64'(DEPTH));
      chk("credit_ready_low", 64'(req_ready), 64'h0);
      step();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("credit_pop_valid", 64'(rsp_valid), 64'h1);
      chk("credit_pop_not_credited", 64'(req_ready), 64'h0);
      acc = 0;
      for (int n = 0; n < 10; n++) begin
         step();
         rsp_ready = 1'b0;
         req_a[63:32] = 32'hD0000000 + 32'(n);
         @(negedge clk);
         if (req_ready[1]) acc++;
      end
      chk("credit_one_more", 64'(acc), 64'h1);
      chk("credit_ready_low2", 64'(req_ready), 64'h0);
      step();
      clr_req();
      rsp_ready = 1'b1;
      repeat (20) step();
      chk("credit_sb_empty", 64'(sbq.size()), 64'h0);

      // Reset while three operations are in flight.
      do_reset();
      rsp_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         for (int i = 0; i < 3; i++) set_req(i, 32'h11111111 * 32'(i + 1), 32'h5, 32'h6, 32'h7,
                                              2'b01, 2'b10);
         @(negedge clk);
      end
      step();
      clr_req();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_fmau_a", 64'(fmau_a), 64'h0);
      chk("mid_rst_fmau_b", 64'(fmau_b), 64'h0);
      chk("mid_rst_fmau_cd", 64'({fmau_c, fmau_d}), 64'h0);
      chk("mid_rst_fmau_pre", 64'({fmau_in_pre, fmau_out_pre}), 64'h0);
      chk("mid_rst_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'h0);
      chk("mid_rst_req_ready", 64'(req_ready), 64'h0);
      seen = 0;
      for (int n = 0; n < 12; n++) begin
         step();
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("mid_rst_no_rsp", 64'(seen), 64'h0);

      // Push and pop together with DEPTH-1 entries held.
      do_reset();
      rsp_ready = 1'b0;
      for (int n = 0; n < DEPTH - 1; n++) begin
         step();
         set_req(0, 32'hE0000000 + 32'(n), 32'h3, 32'h4, 32'h9, 2'b00, 2'b00);
         @(negedge clk);
      end
      step();
      clr_req();
      repeat (10) step();
      set_req(2, 32'hF00D0000, 32'h1, 32'h1, 32'h1, 2'b10, 2'b10);
      @(negedge clk);
      chk("pp_last_slot", 64'(req_ready), 64'h4);
      step();
      clr_req();
      repeat (LAT) step();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("pp_pop_valid", 64'(rsp_valid), 64'h1);
      step();
      rsp_ready = 1'b0;
      set_req(3, 32'hBEEF0000, 32'h2, 32'h2, 32'h2, 2'b01, 2'b01);
      @(negedge clk);
      chk("pp_count_held", 64'(req_ready), 64'h8);
      step();
      @(negedge clk);
      chk("pp_full_again", 64'(req_ready), 64'h0);
      step();
      clr_req();
      rsp_ready = 1'b1;
      repeat (20) step();
      chk("pp_sb_empty", 64'(sbq.size()), 64'h0);

      // Precision change right after an issue.
      do_reset();
      rsp_ready = 1'b1;
      step();
      set_req(0, 32'h12340000, 32'h1, 32'h2, 32'h3, 2'b01, 2'b10);
      @(negedge clk);
      chk("lock_first", 64'(req_ready), 64'h1);
      step();
      clr_req();
      set_req(1, 32'h56780000, 32'h4, 32'h5, 32'h6, 2'b00, 2'b10);
      stall = 0;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (req_ready[1]) got = 1'b1;
         else begin
            stall++;
            step();
         end
      end
`ifdef FMAU_SCHED_PREC_LOCK_EN
      chk("lock_stall_cycles", 64'(stall), 64'(LAT + 1));
`else
      chk("lock_stall_cycles", 64'(stall), 64'h0);
`endif
      step();
      clr_req();
      @(negedge clk);
      chk("lock_new_pre", 64'(fmau_in_pre), 64'h0);
      repeat (10) step();
      chk("lock_sb_empty", 64'(sbq.size()), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
